// File: rtl/mem_stage.sv
// Memory stage: performs byte/word loads and stores over a req/ack data bus,
// stalls upstream while an access is in flight, and forwards results to Writeback.
module mem_stage #(
   parameter int                      ADDR_WIDTH     = 32,
   parameter int                      TIMEOUT_CYCLES = 16,
   parameter int                      OPCODE_WIDTH   = 8,
   parameter logic [OPCODE_WIDTH-1:0] OP_LDB         = 'h20,
   parameter logic [OPCODE_WIDTH-1:0] OP_LDW         = 'h21,
   parameter logic [OPCODE_WIDTH-1:0] OP_STB         = 'h22,
   parameter logic [OPCODE_WIDTH-1:0] OP_STW         = 'h23
) (
   input  logic                    I_CLOCK,
   input  logic                    I_RESET,
   input  logic                    I_LOCK,
   input  logic [31:0]             I_PC,
   input  logic [31:0]             I_IR,
   input  logic [OPCODE_WIDTH-1:0] I_Opcode,
   input  logic [3:0]              I_DestRegIdx,
   input  logic [31:0]             I_DestValue,
   input  logic [2:0]              I_CCValue,
   input  logic                    I_EX_Valid,
   input  logic [31:0]             I_MARValue,
   input  logic [31:0]             I_MDRValue,
   input  logic                    I_RegWEn,
   input  logic                    I_CCWEn,
   input  logic                    I_DMemAck,
   input  logic [31:0]             I_DMemRData,
   output logic                    O_DMemReq,
   output logic                    O_DMemWe,
   output logic [ADDR_WIDTH-1:0]   O_DMemAddr,
   output logic [31:0]             O_DMemWData,
   output logic [3:0]              O_DMemByteEn,
   output logic                    O_LOCK,
   output logic [31:0]             O_PC,
   output logic [31:0]             O_IR,
   output logic [OPCODE_WIDTH-1:0] O_Opcode,
   output logic [3:0]              O_DestRegIdx,
   output logic [31:0]             O_DestValue,
   output logic [2:0]              O_CCValue,
   output logic                    O_MEM_Valid,
   output logic                    O_RegWEn,
   output logic                    O_CCWEn,
   output logic                    O_MemStall_Signal,
   output logic                    O_RegWEn_Signal,
   output logic                    O_BusError
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [CW-1:0] r_count;
   logic          r_isLoad;
   logic          r_isByte;
   logic [1:0]    r_lane;

   logic          w_isLoad, w_isStore, w_isWord, w_isMem;
   logic          w_misaligned, w_issue, w_accept, w_badAlign, w_timeoutHit, w_stall;
   logic [3:0]    w_byteEn;
   logic [31:0]   w_wData, w_byteShift, w_loadValue;
   logic [2:0]    w_loadCC;

   assign w_isLoad     = (I_Opcode == OP_LDB) || (I_Opcode == OP_LDW);
   assign w_isStore    = (I_Opcode == OP_STB) || (I_Opcode == OP_STW);
   assign w_isWord     = (I_Opcode == OP_LDW) || (I_Opcode == OP_STW);
   assign w_isMem      = w_isLoad || w_isStore;
   assign w_misaligned = w_isWord && (I_MARValue[1:0] != 2'b00);
   assign w_issue      = I_LOCK && I_EX_Valid && w_isMem;
   assign w_accept     = (r_state == S_IDLE) && w_issue && !w_misaligned;
   assign w_badAlign   = (r_state == S_IDLE) && w_issue && w_misaligned;
   assign w_timeoutHit = (r_count == CW'(TIMEOUT_CYCLES - 1));

   assign w_byteEn     = w_isWord ? 4'b1111 : (4'b0001 << I_MARValue[1:0]);
   assign w_wData      = (I_Opcode == OP_STB) ? {4{I_MDRValue[7:0]}} : I_MDRValue;

   // Byte loads pick the lane remembered at request time and zero-extend it.
   assign w_byteShift  = I_DMemRData >> {r_lane, 3'b000};
   assign w_loadValue  = r_isByte ? {24'd0, w_byteShift[7:0]} : I_DMemRData;
   assign w_loadCC     = w_loadValue[31] ? 3'b100 : ((w_loadValue == 32'd0) ? 3'b010 : 3'b001);

   assign O_MemStall_Signal = w_stall;
   assign O_RegWEn_Signal   = I_EX_Valid && (I_RegWEn || w_isLoad);

   always_comb begin
      w_nextState = r_state;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_nextState = S_WAIT;
               w_stall     = 1'b1;
            end
         end
         S_WAIT: begin
            if (I_DMemAck || w_timeoutHit) begin
               w_nextState = S_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
      endcase
   end

   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_count <= '0;
         end else if (r_state == S_WAIT) begin
            r_count <= r_count + CW'(1);
         end
      end
   end

   // Instruction fields are captured at acceptance and simply held in the
   // output registers during WAIT; completion only rewrites result and enables.
   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         O_DMemReq    <= 1'b0;
         O_DMemWe     <= 1'b0;
         O_DMemAddr   <= '0;
         O_DMemWData  <= '0;
         O_DMemByteEn <= '0;
         O_LOCK       <= 1'b0;
         O_PC         <= '0;
         O_IR         <= '0;
         O_Opcode     <= '0;
         O_DestRegIdx <= '0;
         O_DestValue  <= '0;
         O_CCValue    <= '0;
         O_MEM_Valid  <= 1'b0;
         O_RegWEn     <= 1'b0;
         O_CCWEn      <= 1'b0;
         O_BusError   <= 1'b0;
         r_isLoad     <= 1'b0;
         r_isByte     <= 1'b0;
         r_lane       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               O_LOCK       <= I_LOCK;
               O_PC         <= I_PC;
               O_IR         <= I_IR;
               O_Opcode     <= I_Opcode;
               O_DestRegIdx <= I_DestRegIdx;
               O_DestValue  <= I_DestValue;
               O_CCValue    <= I_CCValue;
               if (w_accept) begin
                  O_MEM_Valid  <= 1'b0;
                  O_RegWEn     <= 1'b0;
                  O_CCWEn      <= 1'b0;
                  O_DMemReq    <= 1'b1;
                  O_DMemWe     <= w_isStore;
                  O_DMemAddr   <= {I_MARValue[ADDR_WIDTH-1:2], 2'b00};
                  O_DMemWData  <= w_wData;
                  O_DMemByteEn <= w_byteEn;
                  r_isLoad     <= w_isLoad;
                  r_isByte     <= !w_isWord;
                  r_lane       <= I_MARValue[1:0];
               end else if (w_badAlign) begin
                  O_MEM_Valid <= 1'b1;
                  O_RegWEn    <= 1'b0;
                  O_CCWEn     <= 1'b0;
                  O_BusError  <= 1'b1;
               end else begin
                  O_MEM_Valid <= I_EX_Valid && I_LOCK;
                  O_RegWEn    <= I_RegWEn && I_LOCK;
                  O_CCWEn     <= I_CCWEn && I_LOCK;
               end
            end
            S_WAIT: begin
               if (I_DMemAck || w_timeoutHit) begin
                  O_DMemReq   <= 1'b0;
                  O_MEM_Valid <= 1'b1;
                  O_LOCK      <= 1'b1;
                  if (I_DMemAck && r_isLoad) begin
                     O_DestValue <= w_loadValue;
                     O_CCValue   <= w_loadCC;
                     O_RegWEn    <= 1'b1;
                     O_CCWEn     <= 1'b1;
                  end else begin
                     O_RegWEn <= 1'b0;
                     O_CCWEn  <= 1'b0;
                  end
                  if (!I_DMemAck) begin
                     O_BusError <= 1'b1;
                  end
               end else begin
                  O_MEM_Valid <= 1'b0;
                  O_RegWEn    <= 1'b0;
                  O_CCWEn     <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected Writeback
// results; a monitor pops and compares whenever O_MEM_Valid is seen.
module tb_mem_stage;

   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_LDB = 8'h20;
   localparam logic [7:0] OP_LDW = 8'h21;
   localparam logic [7:0] OP_STB = 8'h22;
   localparam logic [7:0] OP_STW = 8'h23;

   logic        I_CLOCK, I_RESET, I_LOCK, I_EX_Valid, I_RegWEn, I_CCWEn, I_DMemAck;
   logic [31:0] I_PC, I_IR, I_DestValue, I_MARValue, I_MDRValue, I_DMemRData;
   logic [7:0]  I_Opcode;
   logic [3:0]  I_DestRegIdx;
   logic [2:0]  I_CCValue;
   logic        O_DMemReq, O_DMemWe, O_LOCK, O_MEM_Valid, O_RegWEn, O_CCWEn;
   logic        O_MemStall_Signal, O_RegWEn_Signal, O_BusError;
   logic [31:0] O_DMemAddr, O_DMemWData, O_PC, O_IR, O_DestValue;
   logic [3:0]  O_DMemByteEn, O_DestRegIdx;
   logic [7:0]  O_Opcode;
   logic [2:0]  O_CCValue;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  dest;
      logic [31:0] value;
      logic [2:0]  cc;
      logic        regWEn;
      logic        ccWEn;
   } expect_t;

   expect_t sbQueue[$];
   int vectors    = 0;
   int miscompares = 0;

   mem_stage #(
      .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16), .OPCODE_WIDTH(8),
      .OP_LDB(OP_LDB), .OP_LDW(OP_LDW), .OP_STB(OP_STB), .OP_STW(OP_STW)
   ) dut (
      .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_PC(I_PC), .I_IR(I_IR),
      .I_Opcode(I_Opcode), .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue),
      .I_CCValue(I_CCValue), .I_EX_Valid(I_EX_Valid), .I_MARValue(I_MARValue),
      .I_MDRValue(I_MDRValue), .I_RegWEn(I_RegWEn), .I_CCWEn(I_CCWEn),
      .I_DMemAck(I_DMemAck), .I_DMemRData(I_DMemRData),
      .O_DMemReq(O_DMemReq), .O_DMemWe(O_DMemWe), .O_DMemAddr(O_DMemAddr),
      .O_DMemWData(O_DMemWData), .O_DMemByteEn(O_DMemByteEn), .O_LOCK(O_LOCK),
      .O_PC(O_PC), .O_IR(O_IR), .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx),
      .O_DestValue(O_DestValue), .O_CCValue(O_CCValue), .O_MEM_Valid(O_MEM_Valid),
      .O_RegWEn(O_RegWEn), .O_CCWEn(O_CCWEn), .O_MemStall_Signal(O_MemStall_Signal),
      .O_RegWEn_Signal(O_RegWEn_Signal), .O_BusError(O_BusError)
   );

   // Clock starts high so the first active (falling) edge is at 5.
   initial I_CLOCK = 1'b1;
   always #5 I_CLOCK = ~I_CLOCK;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic idleInputs();
      I_LOCK = 1'b1; I_EX_Valid = 1'b0; I_RegWEn = 1'b0; I_CCWEn = 1'b0;
      I_Opcode = OP_ADD; I_PC = '0; I_IR = '0; I_DestRegIdx = '0; I_DestValue = '0;
      I_CCValue = '0; I_MARValue = '0; I_MDRValue = '0; I_DMemAck = 1'b0; I_DMemRData = '0;
   endtask

   task automatic applyStimulus(input logic [7:0] op, input logic [31:0] pc, input logic [3:0] dest,
                                input logic [31:0] destVal, input logic [2:0] cc,
                                input logic [31:0] mar, input logic [31:0] mdr,
                                input logic regWEn, input logic ccWEn, input logic lock);
      I_Opcode = op; I_PC = pc; I_IR = {op, 24'h000123}; I_DestRegIdx = dest;
      I_DestValue = destVal; I_CCValue = cc; I_MARValue = mar; I_MDRValue = mdr;
      I_RegWEn = regWEn; I_CCWEn = ccWEn; I_LOCK = lock; I_EX_Valid = 1'b1;
   endtask

   task automatic pushExpect(input logic [31:0] pc, input logic [3:0] dest, input logic [31:0] value,
                             input logic [2:0] cc, input logic regWEn, input logic ccWEn);
      expect_t e;
      e.pc = pc; e.dest = dest; e.value = value; e.cc = cc; e.regWEn = regWEn; e.ccWEn = ccWEn;
      sbQueue.push_back(e);
   endtask

   // Called at the posedge where the instruction was driven; behaves like a
   // stalled Execute stage and presents idle inputs once stall drops.
   task automatic runMem(input string tag, input int ackAt, input logic [31:0] rdata,
                         input int expCycles, input logic expRegSig, input logic checkBus,
                         input logic [31:0] expAddr, input logic [3:0] expBe,
                         input logic expWe, input logic [31:0] expWData);
      int reqCycles = 0;
      int stallCycles = 0;
      logic done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (c > 0) @(posedge I_CLOCK);
         I_DMemAck   = (c == ackAt);
         I_DMemRData = (c == ackAt) ? rdata : 32'hDEADBEEF;
         #1;
         if (c == 0) checkOutput({tag, " regwen signal"}, O_RegWEn_Signal, expRegSig);
         reqCycles   += int'(O_DMemReq);
         stallCycles += int'(O_MemStall_Signal);
         if (c == 1 && checkBus) begin
            checkOutput({tag, " addr"}, O_DMemAddr, expAddr);
            checkOutput({tag, " byteen"}, O_DMemByteEn, expBe);
            checkOutput({tag, " we"}, O_DMemWe, expWe);
            if (expWe) checkOutput({tag, " wdata"}, O_DMemWData, expWData);
         end
         if (!O_MemStall_Signal) done = 1'b1;
      end
      checkOutput({tag, " stall released"}, done, 1'b1);
      @(posedge I_CLOCK);
      idleInputs();
      #1;
      checkOutput({tag, " req cycles"}, reqCycles, expCycles);
      checkOutput({tag, " stall cycles"}, stallCycles, expCycles);
      checkOutput({tag, " req low after"}, O_DMemReq, 1'b0);
   endtask

   initial begin : monitor
      expect_t e;
      forever begin
         @(posedge I_CLOCK);
         if (O_MEM_Valid === 1'b1) begin
            if (sbQueue.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected output: got valid with pc %h, expected none", O_PC);
            end else begin
               e = sbQueue.pop_front();
               checkOutput("wb pc", O_PC, e.pc);
               checkOutput("wb dest", O_DestRegIdx, e.dest);
               checkOutput("wb value", O_DestValue, e.value);
               checkOutput("wb cc", O_CCValue, e.cc);
               checkOutput("wb regwen", O_RegWEn, e.regWEn);
               checkOutput("wb ccwen", O_CCWEn, e.ccWEn);
            end
         end
      end
   end

   initial begin
      idleInputs();
      I_RESET = 1'b1;
      repeat (2) @(posedge I_CLOCK);
      #1;
      checkOutput("reset valid", O_MEM_Valid, 1'b0);
      checkOutput("reset req", O_DMemReq, 1'b0);
      checkOutput("reset buserr", O_BusError, 1'b0);
      checkOutput("reset destvalue", O_DestValue, 32'h0);
      checkOutput("reset regwen", O_RegWEn, 1'b0);
      I_RESET = 1'b0;

      @(posedge I_CLOCK);
      applyStimulus(OP_ADD, 32'h100, 4'd3, 32'd5, 3'b001, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
      pushExpect(32'h100, 4'd3, 32'd5, 3'b001, 1'b1, 1'b1);
      #1;
      checkOutput("add stall", O_MemStall_Signal, 1'b0);
      checkOutput("add regwen signal", O_RegWEn_Signal, 1'b1);
      @(posedge I_CLOCK);
      idleInputs();
      #1;
      checkOutput("add req", O_DMemReq, 1'b0);

      @(posedge I_CLOCK);
      applyStimulus(OP_STW, 32'h104, 4'd4, 32'h77, 3'b010, 32'h40, 32'hCAFEBABE, 1'b0, 1'b0, 1'b1);
      pushExpect(32'h104, 4'd4, 32'h77, 3'b010, 1'b0, 1'b0);
      runMem("stw", 2, 32'h0, 2, 1'b0, 1'b1, 32'h40, 4'b1111, 1'b1, 32'hCAFEBABE);

      @(posedge I_CLOCK);
      applyStimulus(OP_LDB, 32'h108, 4'd5, 32'h0, 3'b000, 32'h43, 32'h0, 1'b1, 1'b1, 1'b1);
      pushExpect(32'h108, 4'd5, 32'h00000080, 3'b001, 1'b1, 1'b1);
      runMem("ldb lane3", 1, 32'h80112233, 1, 1'b1, 1'b1, 32'h40, 4'b1000, 1'b0, 32'h0);

      @(posedge I_CLOCK);
      applyStimulus(OP_LDW, 32'h10C, 4'd6, 32'h0, 3'b000, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
      pushExpect(32'h10C, 4'd6, 32'hFFFFFFFE, 3'b100, 1'b1, 1'b1);
      runMem("ldw neg", 3, 32'hFFFFFFFE, 3, 1'b1, 1'b1, 32'h10, 4'b1111, 1'b0, 32'h0);

      @(posedge I_CLOCK);
      applyStimulus(OP_LDB, 32'h110, 4'd7, 32'h0, 3'b000, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1);
      pushExpect(32'h110, 4'd7, 32'h0, 3'b010, 1'b1, 1'b1);
      runMem("ldb zero", 1, 32'h12345600, 1, 1'b1, 1'b1, 32'h20, 4'b0001, 1'b0, 32'h0);

      @(posedge I_CLOCK);
      applyStimulus(OP_STB, 32'h114, 4'd8, 32'h99, 3'b100, 32'h22, 32'h000000AB, 1'b0, 1'b0, 1'b1);
      pushExpect(32'h114, 4'd8, 32'h99, 3'b100, 1'b0, 1'b0);
      runMem("stb lane2", 2, 32'h0, 2, 1'b0, 1'b1, 32'h20, 4'b0100, 1'b1, 32'hABABABAB);

      // Ack arriving in the very cycle the timeout would fire is a success.
      @(posedge I_CLOCK);
      applyStimulus(OP_LDW, 32'h118, 4'd9, 32'h0, 3'b000, 32'h30, 32'h0, 1'b1, 1'b1, 1'b1);
      pushExpect(32'h118, 4'd9, 32'h1, 3'b001, 1'b1, 1'b1);
      runMem("ldw late ack", 16, 32'h00000001, 16, 1'b1, 1'b1, 32'h30, 4'b1111, 1'b0, 32'h0);
      checkOutput("buserr after late ack", O_BusError, 1'b0);

      @(posedge I_CLOCK);
      applyStimulus(OP_ADD, 32'h11C, 4'd1, 32'h55, 3'b001, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      #1;
      checkOutput("unlocked add stall", O_MemStall_Signal, 1'b0);
      @(posedge I_CLOCK);
      applyStimulus(OP_LDW, 32'h120, 4'd1, 32'h0, 3'b000, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("unlocked add valid", O_MEM_Valid, 1'b0);
      checkOutput("unlocked add regwen", O_RegWEn, 1'b0);
      checkOutput("unlocked ldw stall", O_MemStall_Signal, 1'b0);
      @(posedge I_CLOCK);
      idleInputs();
      #1;
      checkOutput("unlocked ldw req", O_DMemReq, 1'b0);

      @(posedge I_CLOCK);
      applyStimulus(OP_LDW, 32'h124, 4'd2, 32'h1234, 3'b010, 32'h41, 32'h0, 1'b0, 1'b0, 1'b1);
      pushExpect(32'h124, 4'd2, 32'h1234, 3'b010, 1'b0, 1'b0);
      runMem("ldw misaligned", -1, 32'h0, 0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
      checkOutput("misaligned buserr", O_BusError, 1'b1);

      @(posedge I_CLOCK);
      I_RESET = 1'b1;
      @(posedge I_CLOCK);
      #1;
      checkOutput("buserr cleared by reset", O_BusError, 1'b0);
      I_RESET = 1'b0;

      @(posedge I_CLOCK);
      applyStimulus(OP_LDW, 32'h128, 4'd3, 32'hABCD, 3'b001, 32'h50, 32'h0, 1'b0, 1'b0, 1'b1);
      pushExpect(32'h128, 4'd3, 32'hABCD, 3'b001, 1'b0, 1'b0);
      runMem("ldw timeout", -1, 32'h0, 16, 1'b1, 1'b1, 32'h50, 4'b1111, 1'b0, 32'h0);
      checkOutput("timeout buserr", O_BusError, 1'b1);

      @(posedge I_CLOCK);
      applyStimulus(OP_LDW, 32'h12C, 4'd4, 32'h0, 3'b000, 32'h60, 32'h0, 1'b1, 1'b1, 1'b1);
      @(posedge I_CLOCK);
      #1;
      checkOutput("midwait req", O_DMemReq, 1'b1);
      @(posedge I_CLOCK);
      I_RESET = 1'b1;
      idleInputs();
      @(posedge I_CLOCK);
      #1;
      checkOutput("midwait reset req", O_DMemReq, 1'b0);
      checkOutput("midwait reset valid", O_MEM_Valid, 1'b0);
      checkOutput("midwait reset buserr", O_BusError, 1'b0);
      checkOutput("midwait reset stall", O_MemStall_Signal, 1'b0);
      I_RESET = 1'b0;
      @(posedge I_CLOCK);
      I_DMemAck = 1'b1;
      I_DMemRData = 32'h11111111;
      #1;
      checkOutput("stray ack stall", O_MemStall_Signal, 1'b0);
      @(posedge I_CLOCK);
      I_DMemAck = 1'b0;
      #1;
      checkOutput("stray ack valid", O_MEM_Valid, 1'b0);
      checkOutput("stray ack req", O_DMemReq, 1'b0);

      repeat (2) @(posedge I_CLOCK);
      #1;
      checkOutput("scoreboard drained", sbQueue.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
